// File: rtl/lookup_engine.sv
// rtl/lookup_engine.sv - 3-stage ternary-match lookup engine with per-entry action and hit/miss counters
// Configurable table of value/care/action entries; the lowest matching index wins.
module lookup_engine #(
  parameter int  KEY_LEN   = 896,
  parameter int  MASK_LEN  = 896,
  parameter int  ENTRY_NUM = 16,
  parameter int  ACT_LEN   = 64,
  localparam int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                axis_clk,
  input  logic                aresetn,
  input  logic                key_valid,
  input  logic [KEY_LEN-1:0]  extract_key,
  input  logic                key_mask_valid,
  input  logic [MASK_LEN-1:0] key_mask,
  input  logic                cfg_wr_en,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic                cfg_entry_vld,
  input  logic [KEY_LEN-1:0]  cfg_val,
  input  logic [KEY_LEN-1:0]  cfg_care,
  input  logic [ACT_LEN-1:0]  cfg_action,
  output logic                lookup_valid,
  output logic                lookup_hit,
  output logic [IDX_W-1:0]    lookup_index,
  output logic [ACT_LEN-1:0]  lookup_action,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  logic [ENTRY_NUM-1:0] entry_vld_q;
  logic [KEY_LEN-1:0]   val_q    [ENTRY_NUM];
  logic [KEY_LEN-1:0]   care_q   [ENTRY_NUM];
  logic [ACT_LEN-1:0]   action_q [ENTRY_NUM];

  logic                 s1_vld_q;
  logic [KEY_LEN-1:0]   s1_key_q;
  logic [KEY_LEN-1:0]   s1_mask_q;
  logic [KEY_LEN-1:0]   eff_mask_d;

  logic                 s2_vld_q;
  logic [ENTRY_NUM-1:0] match_d;
  logic [ENTRY_NUM-1:0] s2_match_q;

  logic                 hit_d;
  logic [IDX_W-1:0]     idx_d;
  logic [ACT_LEN-1:0]   act_d;

  logic                 valid_q;
  logic                 hit_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ACT_LEN-1:0]   act_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  // Table payload carries no reset; only the valid bits gate matching.
  always_ff @(posedge axis_clk) begin
    if (cfg_wr_en) begin
      val_q[cfg_addr]    <= cfg_val;
      care_q[cfg_addr]   <= cfg_care;
      action_q[cfg_addr] <= cfg_action;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      entry_vld_q <= '0;
    end else if (cfg_wr_en) begin
      entry_vld_q[cfg_addr] <= cfg_entry_vld;
    end
  end

  assign eff_mask_d = key_mask_valid ? KEY_LEN'(key_mask) : '1;

  always_comb begin
    match_d = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      match_d[i] = entry_vld_q[i] &&
                   (((s1_key_q ^ val_q[i]) & care_q[i] & s1_mask_q) == '0);
    end
  end

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (s2_match_q[i]) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
      end
    end
    act_d = hit_d ? action_q[idx_d] : '0;
  end

  always_ff @(posedge axis_clk) begin
    if (key_valid) begin
      s1_key_q  <= extract_key;
      s1_mask_q <= eff_mask_d;
    end
    if (s1_vld_q) begin
      s2_match_q <= match_d;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      act_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      s1_vld_q <= key_valid;
      s2_vld_q <= s1_vld_q;
      valid_q  <= s2_vld_q;
      if (s2_vld_q) begin
        hit_q <= hit_d;
        idx_q <= idx_d;
        act_q <= act_d;
        if (hit_d && hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + 32'd1;
        end
        if (!hit_d && miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign lookup_valid  = valid_q;
  assign lookup_hit    = hit_q;
  assign lookup_index  = idx_q;
  assign lookup_action = act_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule
